sdram_port_arbiter: RTL and testbench

Arbitrates the single SDRAM controller port between the video line fetcher and the drawing engine. The video line fetcher reads 128-bit words into the line buffer; the drawing engine reads and writes the back frame buffer. The block sits between both requesters and the SDRAM controller and forwards one transaction at a time. Video gets priority, with a starvation guard for drawing and an acknowledge watchdog.

---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/sdram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;
  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 128;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_DRW  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_VID = 2'd1,
    ST_GNT_DRW = 2'd2
  } arb_state_e;
endpackage

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between video fetch (priority) and the
// drawing engine, with a draw starvation guard and an ack watchdog.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int DRAW_MAX_WAIT = 8,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vid_req,
  input  logic [SDRAM_AW-1:0] vid_addr,
  output logic                vid_ack,
  input  logic                drw_rd,
  input  logic                drw_wr,
  input  logic [SDRAM_AW-1:0] drw_addr,
  input  logic [SDRAM_DW-1:0] drw_wdata,
  output logic                drw_ack,
  output logic                sdram_rd,
  output logic                sdram_wr,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic [SDRAM_DW-1:0] sdram_wdata,
  input  logic                sdram_ac,
  input  logic                sdram_Wait,
  output logic [1:0]          owner,
  output logic                timeout_err
);
  localparam int             WCW      = $clog2(DRAW_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DRAW_MAX_WAIT);
  localparam logic [7:0]     TMO_LAST = 8'(ACK_TIMEOUT - 1);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     tmo_cnt_q, tmo_cnt_d;
  logic           terr_q, terr_d;
  logic           drw_pend;

  assign drw_pend    = drw_rd | drw_wr;
  assign timeout_err = terr_q & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    terr_d      = terr_q;
    vid_ack     = 1'b0;
    drw_ack     = 1'b0;
    sdram_rd    = 1'b0;
    sdram_wr    = 1'b0;
    sdram_addr  = '0;
    sdram_wdata = '0;
    owner       = OWN_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (!sdram_Wait) begin
          if (drw_pend && wait_cnt_q == WAIT_MAX) begin
            state_d    = ST_GNT_DRW;
            wait_cnt_d = '0;
            tmo_cnt_d  = '0;
          end else if (vid_req) begin
            state_d   = ST_GNT_VID;
            tmo_cnt_d = '0;
            // first branch already caught the saturated case
            if (drw_pend) wait_cnt_d = wait_cnt_q + 1'b1;
          end else if (drw_pend) begin
            state_d    = ST_GNT_DRW;
            wait_cnt_d = '0;
            tmo_cnt_d  = '0;
          end
        end
      end
      ST_GNT_VID: begin
        owner      = OWN_VID;
        sdram_rd   = vid_req;
        sdram_addr = vid_addr;
        if (sdram_ac) begin
          vid_ack = 1'b1;
          state_d = ST_IDLE;
        end else if (!vid_req) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_GNT_DRW: begin
        owner       = OWN_DRW;
        sdram_rd    = drw_rd & ~drw_wr;
        sdram_wr    = drw_wr;
        sdram_addr  = drw_addr;
        sdram_wdata = drw_wdata;
        if (sdram_ac) begin
          drw_ack = 1'b1;
          state_d = ST_IDLE;
        end else if (!drw_pend) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs read as idle while reset is held, even before the clock edge.
    if (reset) begin
      vid_ack     = 1'b0;
      drw_ack     = 1'b0;
      sdram_rd    = 1'b0;
      sdram_wr    = 1'b0;
      sdram_addr  = '0;
      sdram_wdata = '0;
      owner       = OWN_NONE;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench: stimulus predicts each grant from the
// arbitration rules; a negedge monitor checks grants, acks and idle outputs.
module tb_sdram_port_arbiter;
  localparam int MAXW = 8;

  logic         clock = 0;
  logic         reset = 1;
  logic         vid_req = 0, drw_rd = 0, drw_wr = 0, sdram_ac = 0, sdram_Wait = 0;
  logic [21:0]  vid_addr = '0, drw_addr = '0;
  logic [127:0] drw_wdata = '0;
  logic         vid_ack, drw_ack, sdram_rd, sdram_wr, timeout_err;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic [1:0]   owner;

  sdram_port_arbiter #(.DRAW_MAX_WAIT(MAXW), .ACK_TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .drw_rd(drw_rd), .drw_wr(drw_wr), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_ack(drw_ack), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_ac(sdram_ac), .sdram_Wait(sdram_Wait),
    .owner(owner), .timeout_err(timeout_err));

  always #5 clock = ~clock;

  typedef struct {
    int           own;
    bit           rd, wr;
    logic [21:0]  addr;
    logic [127:0] wdata;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0, mismatched = 0;
  int   cyc = 0;
  int   mwait = 0;
  bit   exp_terr = 0;
  int   prev_own = 0, cur_own = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, expv, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      chk("reset_outputs", {vid_ack, drw_ack, sdram_rd, sdram_wr, owner, timeout_err, sdram_addr},
          '0);
      chk("reset_wdata", sdram_wdata, '0);
      prev_own = 0;
      cur_own  = 0;
    end else begin
      if (owner != 0 && prev_own == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant_owner", 128'(owner), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("grant_owner", 128'(owner), 128'(e.own));
          chk("grant_cycle", 128'(cyc), 128'(e.cyc));
          chk("grant_strobes", {sdram_rd, sdram_wr}, {e.rd, e.wr});
          chk("grant_addr", 128'(sdram_addr), 128'(e.addr));
          if (e.own == 2) chk("grant_wdata", sdram_wdata, e.wdata);
          cur_own = e.own;
        end
      end
      if (owner == 0) begin
        cur_own = 0;
        chk("idle_outputs", {sdram_rd, sdram_wr, sdram_addr}, '0);
        chk("idle_wdata", sdram_wdata, '0);
      end
      if (sdram_ac && cur_own != 0)
        chk("ack_route", {vid_ack, drw_ack}, {cur_own == 1, cur_own == 2});
      else
        chk("no_ack", {vid_ack, drw_ack}, '0);
      chk("timeout_err", 128'(timeout_err), 128'(exp_terr));
      prev_own = owner;
    end
  end

  // One arbitration round: optionally raise requests, optionally hold Wait,
  // predict the grant, play controller (ack after acd+1 cycles, or never).
  task automatic do_round(input bit add_v, input bit add_d, input bit d_rd, input bit d_wr,
                          input int wcyc, input int acd);
    exp_t e;
    bit   vp, dp, seen;
    if (add_v && !vid_req) begin
      vid_req = 1; vid_addr = 22'($urandom);
    end
    if (add_d && !(drw_rd | drw_wr) && (d_rd | d_wr)) begin
      drw_rd = d_rd; drw_wr = d_wr; drw_addr = 22'($urandom);
      drw_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    vp = vid_req; dp = drw_rd | drw_wr;
    if (!vp && !dp) return;
    if (wcyc > 0) begin
      sdram_Wait = 1;
      repeat (wcyc) @(posedge clock);
      #1 sdram_Wait = 0;
    end
    if (dp && mwait == MAXW) begin
      e.own = 2; mwait = 0;
    end else if (vp) begin
      e.own = 1;
      if (dp && mwait < MAXW) mwait++;
    end else begin
      e.own = 2; mwait = 0;
    end
    if (e.own == 1) begin
      e.rd = 1; e.wr = 0; e.addr = vid_addr; e.wdata = '0;
    end else begin
      e.rd = drw_rd & ~drw_wr; e.wr = drw_wr; e.addr = drw_addr; e.wdata = drw_wdata;
    end
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clock);
      seen = sdram_rd | sdram_wr;
    end
    if (!seen) begin
      mismatched++;
      $display("FAIL grant_wait: no strobe within 4 cycles, expected owner %0d", e.own);
      finish_run();
    end
    if (acd >= 0) begin
      repeat (acd + 1) @(posedge clock);
      #1 sdram_ac = 1;
      @(posedge clock);
      #1 sdram_ac = 0;
    end else begin
      repeat (255) @(posedge clock);
      #1 exp_terr = 1;
    end
    if (e.own == 1) vid_req = 0;
    else begin drw_rd = 0; drw_wr = 0; end
  endtask

  task automatic drain();
    int guard = 0;
    while ((vid_req || drw_rd || drw_wr) && guard < 20) begin
      do_round(0, 0, 0, 0, 0, int'($urandom_range(0, 2)));
      guard++;
    end
  endtask

  initial begin
    int r, w;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(posedge clock);
    #1;
    // Basic video read, ack three cycles after the strobe
    vid_req = 1; vid_addr = 22'h100028;
    do_round(0, 0, 0, 0, 0, 2);
    // Read+write together behaves as a write
    do_round(0, 1, 1, 1, 0, 1);
    // Video held with a draw write pending: starvation guard kicks in
    for (int i = 0; i < 10; i++) do_round(1, 1, 0, 1, 0, 0);
    drain();
    // Controller busy with both requesters waiting
    do_round(1, 1, 1, 0, 20, 0);
    drain();
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(1, 3));
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r[0], r[1], w,
               int'($urandom_range(0, 3)));
    end
    drain();
    // Ack lands on the last watchdog cycle: ack wins
    do_round(0, 1, 0, 1, 0, 253);
    // No ack at all: watchdog abandons the draw read
    do_round(0, 1, 1, 0, 0, -1);
    do_round(1, 0, 0, 0, 0, 1);
    // Reset in the middle of a video grant, then a stray ack
    vid_req = 1; vid_addr = 22'($urandom);
    exp_q.push_back('{own: 1, rd: 1, wr: 0, addr: vid_addr, wdata: '0, cyc: cyc + 1});
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1; vid_req = 0; mwait = 0; exp_terr = 0;
    @(posedge clock);
    #1 reset = 0; sdram_ac = 1;
    @(posedge clock);
    #1 sdram_ac = 0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(1, 3));
      do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r[0], r[1], 0,
               int'($urandom_range(0, 3)));
    end
    drain();
    repeat (3) @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    finish_run();
  end

  initial begin
    repeat (60000) @(posedge clock);
    mismatched++;
    $display("FAIL global_timeout: run exceeded 60000 cycles");
    finish_run();
  end
endmodule
